// File: rtl/capture_engine.sv
// capture_engine: prescaled probe sampler with edge trigger and a
// circular pre/post-trigger capture into an external sample RAM.
// Ports: clk, rst (sync, active-high); probes, PRESCALING_FACTOR,
//   TRIGGER_KIND, arm in; wr_en/wr_addr/wr_data RAM write port out;
//   busy, triggered, done, trig_addr status out.
module capture_engine #(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       probes,
  input  logic [28:0]       PRESCALING_FACTOR,
  input  logic [1:0]        TRIGGER_KIND [15:0],
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int CW     = ADDR_W + 1;
  localparam int POST_N = DEPTH - PRETRIG;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRETRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_N - 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state;

  logic [15:0]       sync1;
  logic [15:0]       sync2;
  logic [15:0]       sample;
  logic              have_prev;
  logic [28:0]       cnt;
  logic [28:0]       f_eff;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     scnt;

  logic        tick;
  logic        armed;
  logic        do_wr;
  logic        free_run;
  logic [15:0] hit;
  logic        trig;

  // Edges compare the incoming synchronized word against the
  // last captured sample, so the trigger lands with its own write.
  always_comb begin
    f_eff = (PRESCALING_FACTOR == 29'd0) ? 29'd1
                                         : PRESCALING_FACTOR;
    tick  = (cnt >= f_eff - 29'd1);
    armed = arm && (state == S_IDLE || state == S_DONE);
    do_wr = tick && (state == S_PREFILL ||
                     state == S_WAIT    ||
                     state == S_POST);
    free_run = 1'b1;
    hit      = '0;
    for (int i = 0; i < 16; i++) begin
      if (TRIGGER_KIND[i] != 2'b00) free_run = 1'b0;
      hit[i] = (TRIGGER_KIND[i][0] & ~sample[i] & sync2[i]) |
               (TRIGGER_KIND[i][1] & sample[i] & ~sync2[i]);
    end
    trig = have_prev && (free_run || (|hit));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sync1     <= '0;
      sync2     <= '0;
      sample    <= '0;
      have_prev <= 1'b0;
      cnt       <= '0;
      ptr       <= '0;
      scnt      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      trig_addr <= '0;
    end else begin
      sync1 <= probes;
      sync2 <= sync1;
      wr_en <= 1'b0;

      if (armed || tick) cnt <= '0;
      else               cnt <= cnt + 29'd1;

      if (tick) begin
        sample    <= sync2;
        have_prev <= (state != S_IDLE);
      end

      if (do_wr) begin
        wr_en   <= 1'b1;
        wr_addr <= ptr;
        wr_data <= sync2;
        ptr     <= ptr + ONE_A;
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state     <= S_PREFILL;
            ptr       <= '0;
            wr_addr   <= '0;
            scnt      <= '0;
            have_prev <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_PREFILL: begin
          if (tick) begin
            if (scnt == PRE_LAST) begin
              state <= S_WAIT;
              scnt  <= '0;
            end else begin
              scnt <= scnt + ONE_C;
            end
          end
        end
        S_WAIT: begin
          if (tick && trig) begin
            trig_addr <= ptr;
            triggered <= 1'b1;
            scnt      <= ONE_C;
            if (POST_N == 1) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (tick) begin
            if (scnt == POST_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              scnt <= scnt + ONE_C;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_engine.sv
// tb_capture_engine: randomized and directed stimulus against a
// capture-level model (write count, trigger index) of capture_engine.
module tb_capture_engine;

  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [15:0]   probes = '0;
  logic [28:0]   pf = 29'd1;
  logic [1:0]    kind [15:0];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_addr;

  capture_engine #(
    .DEPTH(DEPTH),
    .PRETRIG(PRETRIG),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .probes(probes),
    .PRESCALING_FACTOR(pf),
    .TRIGGER_KIND(kind),
    .arm(arm),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .triggered(triggered),
    .done(done),
    .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: a capture is a run of writes numbered from 0; the
  // address is the write number mod DEPTH; the trigger is the first
  // eligible write at index >= PRETRIG, and the capture ends once
  // DEPTH-PRETRIG writes have been made from the trigger onward.
  bit            started = 0;
  logic [15:0]   h1 = '0;
  logic [15:0]   h2 = '0;
  logic [15:0]   nw;
  longint        m_cnt = 0;
  longint        f;
  bit            tk;
  bit            m_active = 0;
  int            m_writes = 0;
  int            m_trig = -1;
  logic          m_wr_en = 0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [15:0]   m_wr_data = '0;
  logic          m_triggered = 0;
  logic          m_done = 0;
  logic [AW-1:0] m_trig_addr = '0;

  function automatic bit trig_fn(logic [15:0] o, logic [15:0] n);
    bit any = 0;
    bit hit = 0;
    for (int i = 0; i < 16; i++) begin
      if (kind[i] != 2'b00) any = 1;
      if (kind[i][0] && !o[i] && n[i]) hit = 1;
      if (kind[i][1] && o[i] && !n[i]) hit = 1;
    end
    return !any || hit;
  endfunction

  always @(posedge clk) begin
    nw = h2;
    h2 = h1;
    h1 = probes;
    if (rst) begin
      h1 = '0;
      h2 = '0;
      m_cnt = 0;
      m_active = 0;
      m_writes = 0;
      m_trig = -1;
      m_wr_en = 0;
      m_wr_addr = '0;
      m_wr_data = '0;
      m_triggered = 0;
      m_done = 0;
      m_trig_addr = '0;
    end else begin
      f  = (pf == 0) ? 1 : longint'(pf);
      tk = (m_cnt >= f - 1);
      m_wr_en = 0;
      if (!m_active && arm) begin
        m_cnt = 0;
        m_active = 1;
        m_writes = 0;
        m_trig = -1;
        m_wr_addr = '0;
        m_triggered = 0;
        m_done = 0;
      end else begin
        m_cnt = tk ? 0 : m_cnt + 1;
        if (m_active && tk) begin
          if (m_writes >= PRETRIG && m_trig < 0 &&
              m_writes > 0 && trig_fn(m_wr_data, nw)) begin
            m_trig = m_writes;
            m_triggered = 1;
            m_trig_addr = AW'(m_writes % DEPTH);
          end
          m_wr_en = 1;
          m_wr_addr = AW'(m_writes % DEPTH);
          m_wr_data = nw;
          m_writes++;
          if (m_trig >= 0 && m_writes - m_trig == DEPTH - PRETRIG) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if ({wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr} !==
          {m_wr_en, m_wr_addr, m_wr_data, m_active, m_triggered,
           m_done, m_trig_addr}) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t dut en=%b a=%0d d=%h b=%b t=%b dn=%b ta=%0d model en=%b a=%0d d=%h b=%b t=%b dn=%b ta=%0d",
                 $time, wr_en, wr_addr, wr_data, busy, triggered, done,
                 trig_addr, m_wr_en, m_wr_addr, m_wr_data, m_active,
                 m_triggered, m_done, m_trig_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_done(string name, int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (done) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  int  nwr;
  int  npost;
  int  last;
  int  prev_a;
  bit  ok;
  bit  wrapped;
  logic [15:0] p;

  initial begin
    kind = '{default: 2'b00};
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_outputs",
          {wr_en, wr_addr, wr_data, busy, triggered, done, trig_addr}, 0);
    nwr = 0;
    repeat (100) begin
      step();
      if (wr_en || busy || done || triggered) nwr++;
    end
    check("idle_quiet", nwr, 0);

    // prescale F=5, free-run
    pf = 29'd5;
    probes = 16'h5a5a;
    step();
    step();
    do_arm();
    nwr = 0;
    last = 0;
    ok = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (wr_en) begin
        if (nwr == 0) check("pre_first_tick", c, 5);
        else          check("pre_gap", c - last, 5);
        last = c;
        nwr++;
      end
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("pre_done", ok, 1);
    check("pre_writes", nwr, 16);
    check("pre_last_addr", wr_addr, 15);
    check("pre_trig_addr", trig_addr, 4);
    check("pre_busy_low", busy, 0);

    // rising trigger on ch3, F=1
    pf = 29'd1;
    kind[3] = 2'b01;
    probes = '0;
    step();
    step();
    do_arm();
    nwr = 0;
    npost = 0;
    for (int k = 3; k < 120; k++) begin
      p = '0;
      p[0] = k[0];
      p[7] = k[1];
      p[3] = (k == 3 || k == 4 || k >= 9);
      probes = p;
      step();
      if (wr_en) nwr++;
      if (wr_en && triggered) npost++;
      if (done) break;
    end
    check("rise_done", done, 1);
    check("rise_trig_addr", trig_addr, 8);
    check("rise_post_writes", npost, 12);
    check("rise_writes", nwr, 20);

    // both-edge on ch15 with wrap
    kind[3] = 2'b00;
    kind[15] = 2'b11;
    probes = 16'h8000;
    step();
    step();
    do_arm();
    nwr = 0;
    wrapped = 0;
    prev_a = -1;
    for (int k = 3; k < 150; k++) begin
      p = 16'($urandom);
      p[15] = (k <= 40);
      probes = p;
      step();
      if (wr_en) begin
        if (prev_a == 15 && wr_addr == 0) wrapped = 1;
        prev_a = int'(wr_addr);
        nwr++;
      end
      if (done) break;
    end
    check("wrap_done", done, 1);
    check("wrap_trig_addr", trig_addr, 8);
    check("wrap_start", (trig_addr - 4'd4) & 4'hf, 4);
    check("wrap_seen", wrapped, 1);
    check("wrap_writes", nwr, 52);

    // factor change
    kind = '{default: 2'b00};
    pf = 29'd1000;
    do_arm();
    nwr = 0;
    repeat (600) begin
      step();
      if (wr_en) nwr++;
    end
    check("f1000_quiet", nwr, 0);
    pf = 29'd10;
    step();
    check("fchg_tick_next", wr_en, 1);
    last = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (wr_en) begin
        last = c;
        break;
      end
    end
    check("f10_gap", last, 10);
    pf = 29'd0;
    nwr = 0;
    repeat (5) begin
      step();
      if (wr_en) nwr++;
    end
    check("f0_every_cycle", nwr, 5);
    wait_done("fchg_done", 100);

    // arm ignored in WAIT, reset abort in POST, re-arm
    pf = 29'd3;
    kind[3] = 2'b01;
    probes = '0;
    step();
    step();
    do_arm();
    repeat (40) step();
    arm = 1'b1;
    step();
    step();
    arm = 1'b0;
    check("arm_ign_busy", busy, 1);
    check("arm_ign_done", done, 0);
    probes[3] = 1'b1;
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (triggered) begin
        ok = 1;
        break;
      end
    end
    check("arm_ign_trig", ok, 1);
    repeat (6) step();
    check("post_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_trig", triggered, 0);
    check("abort_wr_en", wr_en, 0);
    kind = '{default: 2'b00};
    pf = 29'd2;
    do_arm();
    wait_done("rearm_done", 200);
    check("rearm_trig_addr", trig_addr, 4);

    // randomized captures
    for (int r = 0; r < 8; r++) begin
      pf = 29'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++)
        kind[i] = ($urandom_range(0, 3) == 0) ?
                  2'($urandom_range(1, 3)) : 2'b00;
      arm = 1'b1;
      for (int c = 0; c < 250; c++) begin
        if (c > 0) arm = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 2) == 0) probes = 16'($urandom);
        if ($urandom_range(0, 59) == 0)
          pf = 29'($urandom_range(0, 4));
        if ($urandom_range(0, 49) == 0)
          kind[$urandom_range(0, 15)] = 2'($urandom_range(0, 3));
        if (c == 150) kind = '{default: 2'b00};
        rst = ($urandom_range(0, 399) == 0);
        step();
      end
      arm = 1'b0;
      rst = 1'b0;
    end

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
